instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds each instruction for the control unit until it is accepted.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_err,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              w_misaligned;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // Request and fault flags are Moore-decoded so they change only on a state edge.
    assign imem_req    = (r_state == S_FETCH);
    assign fetch_fault = (r_state == S_FAULT);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

    // NOTE: state is updated with non-blocking assignments so every branch below
    // reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (r_state != S_FAULT && redirect_valid) begin
            // A redirect wins over any ack or accept in the same cycle.
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
            r_state       <= w_misaligned ? S_FAULT : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        if (imem_err) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_pc          <= r_pc + ADDR_W'(4);
                            r_instr_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FAULT;
            endcase
        end
    end

endmodule
